// File: rtl/sram_arb_pkg.sv
// Shared defaults, priority-mode encodings and the port-index width helper.
// No logic of its own.
// Not applicable.
package sram_arb_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RD_DEPTH   = 8;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Width needed to hold a port index; never narrower than one bit.
  function automatic int port_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_arb_if.sv
// Bundle of request-port, response and SRAM-command signals of the arbiter.
// Pure wiring, no latency.
// Requests use valid/ready; responses and read data strobes cannot be stalled.
interface sram_arb_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS*MASK_WIDTH-1:0] req_mask;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_data;
  logic                            sram_addr_valid;
  logic                            sram_ready;
  logic [ADDR_WIDTH-1:0]           sram_addr;
  logic [DATA_WIDTH-1:0]           sram_data_in;
  logic [MASK_WIDTH-1:0]           sram_write_mask;
  logic [DATA_WIDTH-1:0]           sram_data_out;
  logic                            sram_data_out_valid;

  // Client engines plus SRAM controller side.
  modport master (
    output req_valid, req_mask, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data,
    input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    output sram_ready, sram_data_out, sram_data_out_valid
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_mask, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data,
    output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    input  sram_ready, sram_data_out, sram_data_out_valid
  );

endinterface

// File: rtl/sram_arb_tag_fifo.sv
// In-flight read tag FIFO: remembers which port issued each outstanding read.
// Pop data is the head entry, valid combinationally while not empty.
// No internal backpressure; caller never pushes when full nor pops when empty.
module sram_arb_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Occupancy follows push/pop; both together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// N-port read/write arbiter feeding one SRAM command register, with read data routed back by tag.
// Grant to sram_addr_valid: 1 cycle; read strobe to rsp_valid: 1 cycle.
// Ports stall while the command register is held or read credit is exhausted; responses cannot stall.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_PORTS     = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH    = DATA_WIDTH / 8,
  parameter int RD_DEPTH      = DEF_RD_DEPTH,
  parameter int PRIORITY_MODE = PRIO_RR
) (
  input  logic                      clock,
  input  logic                      reset,
  sram_arb_if.slave                 bus,
  output logic [$clog2(RD_DEPTH):0] rd_outstanding,
  output logic                      rsp_orphan
);
  localparam int PW = port_w(NUM_PORTS);
  localparam int SW = PW + 1;
  localparam int CW = $clog2(RD_DEPTH) + 1;

  logic [NUM_PORTS-1:0]  is_wr, elig, gnt_oh;
  logic                  credit_ok, cmd_free, gnt_any, grant_fire, push, pop;
  logic [PW-1:0]         gnt_idx, cand, last_q, pop_tag;
  logic [SW-1:0]         sum;
  logic                  fifo_empty;

  logic                  cmd_vld_q, cmd_vld_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [MASK_WIDTH-1:0] cmd_mask_q, cmd_mask_d;
  logic [NUM_PORTS-1:0]  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  orphan_q, orphan_d;

  // Reads are reserved at grant, so credit counts held as well as issued reads.
  assign credit_ok = (rd_outstanding < CW'(RD_DEPTH));
  assign cmd_free  = ~cmd_vld_q | bus.sram_ready;

  // A non-zero mask marks a write; writes bypass read credit.
  always_comb begin
    is_wr = '0;
    elig  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      is_wr[i] = |bus.req_mask[i*MASK_WIDTH +: MASK_WIDTH];
      elig[i]  = bus.req_valid[i] & (is_wr[i] | credit_ok);
    end
  end

  // Pick one eligible port: fixed order from 0, or round-robin starting after last grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    sum     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (PRIORITY_MODE == PRIO_FIXED) begin
        cand = PW'(k);
      end else begin
        sum = SW'(last_q) + SW'(k + 1);
        if (sum >= SW'(NUM_PORTS)) sum = sum - SW'(NUM_PORTS);
        cand = sum[PW-1:0];
      end
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_oh        = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;
  assign grant_fire    = cmd_free & gnt_any;
  assign bus.req_ready = cmd_free ? gnt_oh : '0;
  assign push          = grant_fire & ~is_wr[gnt_idx];
  assign pop           = bus.sram_data_out_valid & ~fifo_empty;

  // Load the command register on a grant, otherwise drop it once the controller takes it.
  always_comb begin
    cmd_vld_d  = cmd_vld_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cmd_mask_d = cmd_mask_q;
    if (grant_fire) begin
      cmd_vld_d  = 1'b1;
      cmd_addr_d = bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      cmd_data_d = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      cmd_mask_d = bus.req_mask[int'(gnt_idx)*MASK_WIDTH +: MASK_WIDTH];
    end else if (bus.sram_ready) begin
      cmd_vld_d  = 1'b0;
    end
  end

  // Returning data goes to the oldest tag; a strobe with nothing pending is flagged sticky.
  always_comb begin
    rsp_vld_d = '0;
    rsp_dat_d = rsp_dat_q;
    orphan_d  = orphan_q;
    if (pop) begin
      rsp_vld_d = NUM_PORTS'(1) << pop_tag;
      rsp_dat_d = bus.sram_data_out;
    end
    if (bus.sram_data_out_valid && fifo_empty) orphan_d = 1'b1;
  end

  // State registers; reset starts round-robin so port 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_vld_q  <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_mask_q <= '0;
      rsp_vld_q  <= '0;
      rsp_dat_q  <= '0;
      orphan_q   <= 1'b0;
      last_q     <= PW'(NUM_PORTS - 1);
    end else begin
      cmd_vld_q  <= cmd_vld_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cmd_mask_q <= cmd_mask_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
      orphan_q   <= orphan_d;
      if (grant_fire) last_q <= gnt_idx;
    end
  end

  sram_arb_tag_fifo #(
    .WIDTH (PW),
    .DEPTH (RD_DEPTH)
  ) u_tag_fifo (
    .clk        (clock),
    .rst        (reset),
    .push_i     (push),
    .push_dat_i (gnt_idx),
    .pop_i      (pop),
    .pop_dat_o  (pop_tag),
    .empty_o    (fifo_empty),
    .count_o    (rd_outstanding)
  );

  assign bus.sram_addr_valid = cmd_vld_q;
  assign bus.sram_addr       = cmd_addr_q;
  assign bus.sram_data_in    = cmd_data_q;
  assign bus.sram_write_mask = cmd_mask_q;
  assign bus.rsp_valid       = rsp_vld_q;
  assign bus.rsp_data        = rsp_dat_q;
  assign rsp_orphan          = orphan_q;

endmodule
